// File: rtl/sub_access_arbiter.sv
// sub_access_arbiter
// Round-robin arbiter that lets NREQ requesters share one sub-block, with
// only one transaction in flight at a time.
//   IDLE  : pick the first requester at or above ptr (wrapping), latch its
//           id and payload, pulse gnt for one cycle.
//   ISSUE : present the latched command until the sub-block takes it.
//   WAIT  : wait for the response, or abort after TIMEOUT edges.
// Handshake: a command transfers on a clk edge where sub_valid=1 and
// sub_ready=1; sub_valid stays high and sub_data stays stable until then.
// sub_rsp_valid is a one-cycle strobe with no back-pressure and is only
// looked at in WAIT. rsp_valid/timeout_err are one-cycle pulses.
// Optional macro SUB_ACCESS_ARBITER_STATS_EN adds a saturating grant_count.
// state_dbg exposes the FSM state (0=IDLE, 1=ISSUE, 2=WAIT).
module sub_access_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DW-1:0]       req_data,
  output logic [NREQ-1:0]          gnt,
  output logic                     sub_valid,
  output logic [DW-1:0]            sub_data,
  input  logic                     sub_ready,
  input  logic                     sub_rsp_valid,
  input  logic [DW-1:0]            sub_rsp_data,
  output logic                     rsp_valid,
  output logic [DW-1:0]            rsp_data,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
`ifdef SUB_ACCESS_ARBITER_STATS_EN
  output logic [15:0]              grant_count,
`endif
  output logic [1:0]               state_dbg,
  output logic                     timeout_err
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = IDW + 1;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] id;
  logic [7:0]     cnt;

  logic [CW-1:0]  cand;
  logic [IDW-1:0] sel_idx;
  logic           sel_found;
  logic [IDW-1:0] ptr_after;

  assign state_dbg = state;

  // Pointer value after a transaction for the latched id completes.
  assign ptr_after = (id == IDW'(NREQ - 1)) ? '0 : id + 1'b1;

  // Round-robin pick: first requesting index at or above ptr, modulo NREQ.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = {1'b0, ptr} + CW'(i);
      if (cand >= CW'(NREQ)) cand = cand - CW'(NREQ);
      if (!sel_found && req[cand[IDW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[IDW-1:0];
      end
    end
  end

  // Main FSM; every output is registered and pulses default low each cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      ptr         <= '0;
      id          <= '0;
      cnt         <= '0;
      gnt         <= '0;
      sub_valid   <= 1'b0;
      sub_data    <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_id      <= '0;
      timeout_err <= 1'b0;
    end else begin
      gnt         <= '0;
      rsp_valid   <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (sel_found) begin
            id        <= sel_idx;
            sub_data  <= req_data[sel_idx*DW +: DW];
            gnt       <= {{(NREQ-1){1'b0}}, 1'b1} << sel_idx;
            sub_valid <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (sub_ready) begin
            sub_valid <= 1'b0;
            cnt       <= '0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A response on the final timeout edge still counts as a response.
          if (sub_rsp_valid) begin
            rsp_valid <= 1'b1;
            rsp_data  <= sub_rsp_data;
            rsp_id    <= id;
            ptr       <= ptr_after;
            state     <= S_IDLE;
          end else if (cnt == CNT_LAST) begin
            timeout_err <= 1'b1;
            rsp_id      <= id;
            ptr         <= ptr_after;
            state       <= S_IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SUB_ACCESS_ARBITER_STATS_EN
  // Grant counter, saturating at all ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_count <= '0;
    end else if (state == S_IDLE && sel_found && grant_count != 16'hFFFF) begin
      grant_count <= grant_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sub_access_arbiter.sv
// Testbench for sub_access_arbiter (NREQ=4, DW=8, TIMEOUT=15).
// Driver tasks push expected grants, commands and responses into queues;
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_sub_access_arbiter;

  localparam int NREQ    = 4;
  localparam int DW      = 8;
  localparam int TIMEOUT = 15;
  localparam int IDW     = 2;
  localparam int RW      = 1 + IDW + DW;

  logic                clk;
  logic                rst;
  logic [NREQ-1:0]     req;
  logic [NREQ*DW-1:0]  req_data;
  logic [NREQ-1:0]     gnt;
  logic                sub_valid;
  logic [DW-1:0]       sub_data;
  logic                sub_ready;
  logic                sub_rsp_valid;
  logic [DW-1:0]       sub_rsp_data;
  logic                rsp_valid;
  logic [DW-1:0]       rsp_data;
  logic [IDW-1:0]      rsp_id;
  logic [1:0]          state_dbg;
  logic                timeout_err;
`ifdef SUB_ACCESS_ARBITER_STATS_EN
  logic [15:0]         grant_count;
`endif

  sub_access_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .req_data      (req_data),
    .gnt           (gnt),
    .sub_valid     (sub_valid),
    .sub_data      (sub_data),
    .sub_ready     (sub_ready),
    .sub_rsp_valid (sub_rsp_valid),
    .sub_rsp_data  (sub_rsp_data),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .rsp_id        (rsp_id),
`ifdef SUB_ACCESS_ARBITER_STATS_EN
    .grant_count   (grant_count),
`endif
    .state_dbg     (state_dbg),
    .timeout_err   (timeout_err)
  );

  // Scoreboard state
  logic [NREQ-1:0] exp_gnt_q[$];
  logic [DW-1:0]   exp_cmd_q[$];
  logic [RW-1:0]   exp_rsp_q[$];   // {is_timeout, id, data}
  int              n_checks = 0;
  int              n_fail   = 0;
  int              m_ptr    = 0;   // reference round-robin pointer
  int              exp_gc   = 0;   // reference grant count
  logic [DW-1:0]   hold_data;
  logic [IDW-1:0]  hold_id;
  int              cyc      = 0;
  int              last_gnt = -1;

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: unexpected output %0h with nothing expected (t=%0t)", name, act, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference rule: first set bit at or above p, wrapping modulo NREQ.
  function automatic int pick(input logic [NREQ-1:0] mask, input int p);
    for (int k = 0; k < NREQ; k++)
      if (mask[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  task automatic do_reset();
    exp_gnt_q.delete();
    exp_cmd_q.delete();
    exp_rsp_q.delete();
    m_ptr  = 0;
    exp_gc = 0;
    req = '0; sub_ready = 1'b0; sub_rsp_valid = 1'b0;
    rst = 1'b1;
    #2;
    check("rst_gnt", 32'(gnt), 0);
    check("rst_sub_valid", 32'(sub_valid), 0);
    check("rst_sub_data", 32'(sub_data), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_data", 32'(rsp_data), 0);
    check("rst_rsp_id", 32'(rsp_id), 0);
    check("rst_timeout_err", 32'(timeout_err), 0);
    check("rst_state_idle", 32'(state_dbg), 0);
`ifdef SUB_ACCESS_ARBITER_STATS_EN
    check("rst_grant_count", 32'(grant_count), 0);
`endif
    tick();
    rst = 1'b0;
  endtask

  // Push expectations for a grant, then wait (bounded) for the DUT grant.
  task automatic issue_grant(input logic [NREQ-1:0] mask, input logic [NREQ*DW-1:0] data,
                             output int winner);
    int waited;
    bit got;
    winner = pick(mask, m_ptr);
    exp_gnt_q.push_back(NREQ'(1) << winner);
    exp_cmd_q.push_back(data[winner*DW +: DW]);
    exp_gc++;
    req = mask;
    req_data = data;
    got = 1'b0;
    waited = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      waited++;
      if (gnt != '0) begin
        got = 1'b1;
        break;
      end
    end
    check("grant_seen", 32'(got), 1);
    check("grant_latency_edges", 32'(waited), 1);
  endtask

  // One full transaction. rsp_lat >= TIMEOUT means no response (abort).
  task automatic run_txn(input logic [NREQ-1:0] mask, input logic [NREQ*DW-1:0] data,
                         input int ready_dly, input int rsp_lat,
                         input logic [DW-1:0] rdata, input bit hold_req);
    int winner;
    issue_grant(mask, data, winner);
    if (!hold_req) begin
      // Dropping req and scrambling payloads must not disturb the latched command.
      req = '0;
      req_data = NREQ*DW'($urandom());
    end
    // ISSUE: stray response strobes here must be ignored.
    for (int d = 0; d < ready_dly; d++) begin
      sub_ready = 1'b0;
      sub_rsp_valid = 1'($urandom_range(0, 1));
      sub_rsp_data = DW'($urandom());
      tick();
    end
    sub_ready = 1'b1;
    sub_rsp_valid = 1'($urandom_range(0, 1));
    sub_rsp_data = DW'($urandom());
    tick();
    sub_ready = 1'b0;
    sub_rsp_valid = 1'b0;
    // WAIT
    if (rsp_lat < TIMEOUT) begin
      repeat (rsp_lat) tick();
      sub_rsp_valid = 1'b1;
      sub_rsp_data = rdata;
      exp_rsp_q.push_back({1'b0, IDW'(winner), rdata});
      tick();
      sub_rsp_valid = 1'b0;
    end else begin
      exp_rsp_q.push_back({1'b1, IDW'(winner), DW'(0)});
      repeat (TIMEOUT) tick();
    end
    m_ptr = (winner + 1) % NREQ;
    if (!hold_req) begin
      // Idle with no requests: ready and response strobes must be ignored.
      sub_ready = 1'b1;
      sub_rsp_valid = 1'b1;
      sub_rsp_data = DW'($urandom());
      tick();
      sub_ready = 1'b0;
      sub_rsp_valid = 1'b0;
    end
  endtask

  // Monitor: compare DUT outputs against the queues, away from the clock edge.
  always @(negedge clk) begin
    logic [RW-1:0] e;
    if (rst) begin
      hold_data = '0;
      hold_id   = '0;
      last_gnt  = -1;
    end else begin
      cyc++;
      if (gnt != '0) begin
        if (exp_gnt_q.size() == 0) unexpected("gnt", 32'(gnt));
        else check("gnt", 32'(gnt), 32'(exp_gnt_q.pop_front()));
        if (last_gnt >= 0) check("gnt_spacing_ge3", 32'((cyc - last_gnt) >= 3), 1);
        last_gnt = cyc;
      end
      if (sub_valid) begin
        if (exp_cmd_q.size() == 0) unexpected("sub_valid", 32'(sub_data));
        else begin
          check("sub_data", 32'(sub_data), 32'(exp_cmd_q[0]));
          if (sub_ready) void'(exp_cmd_q.pop_front());
        end
      end
      if (rsp_valid || timeout_err) begin
        if (exp_rsp_q.size() == 0) unexpected("rsp", {rsp_valid, timeout_err, 22'(0), rsp_data});
        else begin
          e = exp_rsp_q.pop_front();
          check("rsp_valid", 32'(rsp_valid), 32'(!e[RW-1]));
          check("timeout_err", 32'(timeout_err), 32'(e[RW-1]));
          check("rsp_id", 32'(rsp_id), 32'(e[DW +: IDW]));
          if (!e[RW-1]) begin
            check("rsp_data", 32'(rsp_data), 32'(e[DW-1:0]));
            hold_data = e[DW-1:0];
          end
          hold_id = e[DW +: IDW];
        end
      end else begin
        check("rsp_data_hold", 32'(rsp_data), 32'(hold_data));
        check("rsp_id_hold", 32'(rsp_id), 32'(hold_id));
      end
    end
  end

  // Stimulus
  initial begin
    int w;
    logic [NREQ*DW-1:0] d;
    logic [NREQ-1:0] m;
    int lat;
    rst = 1'b1;
    req = '0;
    req_data = '0;
    sub_ready = 1'b0;
    sub_rsp_valid = 1'b0;
    sub_rsp_data = '0;
    tick();
    do_reset();

    // Single request from requester 2
    d = NREQ*DW'($urandom());
    d[23:16] = 8'h08;
    run_txn(4'b0100, d, 0, 0, 8'hA5, 1'b0);

    // Fairness from a fresh pointer: grants 0,1,2,3,0
    do_reset();
    for (int t = 0; t < 5; t++)
      run_txn(4'b1111, NREQ*DW'($urandom()), 0, 0, DW'($urandom()), 1'b1);
    req = '0;

    // Timeout on requester 1, then next grant goes to 2
    run_txn(4'b0010, NREQ*DW'($urandom()), 1, TIMEOUT, 8'h00, 1'b0);
    run_txn(4'b1111, NREQ*DW'($urandom()), 0, 2, DW'($urandom()), 1'b0);

    // Response coinciding with the final timeout edge
    run_txn(4'b1111, NREQ*DW'($urandom()), 0, TIMEOUT - 1, 8'h3C, 1'b0);

    // Reset in the middle of WAIT
    req_data = NREQ*DW'($urandom());
    issue_grant(4'b0010, req_data, w);
    req = '0;
    sub_ready = 1'b1;
    tick();
    sub_ready = 1'b0;
    repeat (5) tick();
    do_reset();
    run_txn(4'b1111, NREQ*DW'($urandom()), 0, 1, 8'h5A, 1'b0);

    // Grant counter after three completed grants from reset
    do_reset();
    for (int t = 0; t < 3; t++)
      run_txn(NREQ'($urandom_range(1, 15)), NREQ*DW'($urandom()), 0, 0, DW'($urandom()), 1'b0);
`ifdef SUB_ACCESS_ARBITER_STATS_EN
    check("grant_count_3", 32'(grant_count), 32'(exp_gc));
`endif

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      m = NREQ'($urandom_range(1, 15));
      case ($urandom_range(0, 3))
        0:       lat = TIMEOUT;
        1:       lat = TIMEOUT - 1;
        default: lat = $urandom_range(0, TIMEOUT - 2);
      endcase
      run_txn(m, NREQ*DW'($urandom()), $urandom_range(0, 3), lat,
              DW'($urandom()), 1'($urandom_range(0, 1)));
    end
    req = '0;
    repeat (4) tick();
`ifdef SUB_ACCESS_ARBITER_STATS_EN
    check("grant_count_end", 32'(grant_count), 32'(exp_gc));
`endif
    check("gnt_queue_drained", 32'(exp_gnt_q.size()), 0);
    check("cmd_queue_drained", 32'(exp_cmd_q.size()), 0);
    check("rsp_queue_drained", 32'(exp_rsp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sub_access_arbiter.md
SUB_ACCESS_ARBITER -- requirements
Module: sub_access_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter DW, default 8, data width of request and response.
REQ-003 SHALL have parameter TIMEOUT, default 15, maximum cycles spent in WAIT before abort (1..255).
REQ-004 SHALL have port clk  input  1  single clock, all state on posedge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port req  input  NREQ  per-requester request level.
REQ-007 SHALL have port req_data  input  NREQ*DW  request payloads, requester i at bits [i*DW +: DW].
REQ-008 SHALL have port gnt  output  NREQ  one-hot grant pulse.
REQ-009 SHALL have port sub_valid  output  1  command valid to the shared sub-block.
REQ-010 SHALL have port sub_data  output  DW  command payload.
REQ-011 SHALL have port sub_ready  input  1  sub-block accepts the command.
REQ-012 SHALL have port sub_rsp_valid  input  1  sub-block response strobe.
REQ-013 SHALL have port sub_rsp_data  input  DW  sub-block response payload.
REQ-014 SHALL have port rsp_valid  output  1  response pulse to the requesters.
REQ-015 SHALL have port rsp_data  output  DW  response payload.
REQ-016 SHALL have port rsp_id  output  $clog2(NREQ)  index of the requester that owns rsp_data or timeout_err.
REQ-017 SHALL have port timeout_err  output  1  abort pulse.

Function
REQ-018 SHALL implement the FSM states IDLE, ISSUE and WAIT; only one transaction is outstanding at a time.
REQ-019 IDLE with req nonzero at an edge: SHALL select the first set bit at or above rotating pointer ptr, wrapping modulo NREQ; latch id and payload; drive gnt one-hot for exactly the next cycle; go to ISSUE.
REQ-020 ISSUE: SHALL hold sub_valid=1 and sub_data=latched payload until sub_ready=1 at an edge, then go to WAIT with sub_valid=0 from the next cycle.
REQ-021 WAIT with sub_rsp_valid=1 at an edge: SHALL pulse rsp_valid for one cycle with rsp_data=sub_rsp_data and rsp_id=latched id; set ptr to (id+1) mod NREQ; go to IDLE.
REQ-022 WAIT timeout: counter clears on WAIT entry; when TIMEOUT edges elapse with no response, SHALL pulse timeout_err for one cycle with rsp_id=id, keep rsp_valid=0, advance ptr as in REQ-021, and go to IDLE.
REQ-023 If sub_rsp_valid and the timeout coincide on the same edge, the response SHALL win and timeout_err SHALL stay 0.
REQ-024 sub_rsp_valid outside WAIT SHALL be ignored; sub_ready outside ISSUE SHALL be ignored.
REQ-025 Deassertion of req after grant SHALL NOT affect the latched transaction.
REQ-026 The earliest next grant SHALL be the cycle after return to IDLE; back-to-back grants SHALL therefore be at least 3 cycles apart.
REQ-027 rsp_data and rsp_id SHALL hold their last values while rsp_valid=0.

Reset
REQ-028 rst=1 SHALL immediately force state=IDLE, ptr=0, timeout counter=0, and gnt, sub_valid, sub_data, rsp_valid, rsp_data, rsp_id and timeout_err to 0, including mid-transaction.
REQ-029 After rst deasserts, the first arbitration SHALL occur at the first clk edge with req nonzero.

Configuration
REQ-030 With SUB_ACCESS_ARBITER_STATS_EN defined: SHALL add output grant_count[15:0], reset 0, incremented on each grant and saturating at 16'hFFFF.
REQ-031 Without SUB_ACCESS_ARBITER_STATS_EN: the grant_count port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification (NREQ=4, DW=8, TIMEOUT=15)
REQ-032 Reset test: rst pulse -> all outputs 0, state IDLE.
REQ-033 Single request: req=4'b0100, req_data[23:16]=8'h08, sub_ready next cycle, rsp 8'hA5 -> gnt=4'b0100, sub_data=8'h08, rsp_valid with rsp_data=8'hA5 and rsp_id=2.
REQ-034 Fairness: req=4'b1111 held, immediate ready and response -> grants in order 0,1,2,3,0.
REQ-035 Timeout: grant to requester 1, no sub_rsp_valid -> timeout_err pulse after 15 cycles in WAIT with rsp_id=1, rsp_valid=0; next grant goes to 2.
REQ-036 Collision: response on the 15th WAIT edge -> rsp_valid=1, timeout_err=0.
REQ-037 Reset mid-WAIT, and stats: rst asserted in WAIT -> outputs 0 and ptr=0; with STATS_EN, 3 completed grants -> grant_count=3.
